// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths and types for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int PC_W = 7;   // 128-word instruction ROM
  localparam int IW   = 16;  // instruction width

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [IW-1:0]   instr_t;

  // One prefetched word together with the address it was read from.
  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry circular prefetch buffer of fetch_entry_t with
//            single-cycle flush. Head is driven straight from storage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,                  // legal range 2..4
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Entry storage: written on push, cleared on reset so the head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; a flush empties the buffer, a same-cycle pop
  // has already been consumed by the controller so nothing else is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage: owns the fetch PC, issues reads to a 1-cycle
//            synchronous ROM, buffers returned words and hands them to the
//            controller over valid/ready. Supports clear, redirect and halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,                  // prefetch entries, 2..4
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_rd_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [IW-1:0] ir_data,
  output logic [PC_W-1:0] ir_pc,
  input  logic          pc_clr,
  input  logic          redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic          halt,
  output logic [CW-1:0] fifo_count
);

  pc_t          fpc;
  pc_t          inflight_pc;
  logic         inflight;
  logic         flush;
  logic         pop;
  logic         push;
  logic [CW:0]  occupancy;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign flush = pc_clr | redirect;
  assign pop   = ir_valid & ir_ready;
  assign push  = inflight & ~flush;

  // Slots already promised after this edge: buffered + returning - leaving.
  // Counting the departing head lets a full-rate stream keep one read issued
  // every cycle; pop <= count always holds, so this never underflows.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  // Read strobe: combinational from the handshake/control inputs by intent.
  assign imem_rd_en = rst_n & ~halt & ~flush & (occupancy < (CW + 1)'(DEPTH));
  assign imem_addr  = fpc;

  // Fetch PC: clear beats redirect, both beat sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= '0;
    end else if (pc_clr) begin
      fpc <= '0;
    end else if (redirect) begin
      fpc <= redirect_pc;
    end else if (imem_rd_en) begin
      fpc <= fpc + pc_t'(1);
    end
  end

  // In-flight tracking: a flush drops the word the ROM returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_rd_en & ~flush;
      if (imem_rd_en) inflight_pc <= fpc;
    end
  end

  assign push_entry = '{instr: imem_data, pc: inflight_pc};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (fifo_count)
  );

  assign ir_valid = (fifo_count != '0);
  assign ir_data  = head.instr;
  assign ir_pc    = head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit: directed scenarios
//            plus a randomized run against a word-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0] imem_data = '0;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [IW-1:0] ir_data;
  logic [PC_W-1:0] ir_pc;
  logic          pc_clr = 1'b0;
  logic          redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic [CW-1:0] fifo_count;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .pc_clr      (pc_clr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  instr_t rom [128];
  always @(posedge clk) if (imem_rd_en) imem_data <= rom[imem_addr];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the controller must see an unbroken address stream
  // starting at the last restart target, and reads follow the same stream.
  int   words_buffered;   // words returned and not yet taken
  int   words_returning;  // read issued last cycle, data arriving now
  pc_t  next_read;        // address the next read must use (= fetch PC)
  pc_t  next_deliver;     // address the next transfer must carry
  logic dut_read_prev;    // DUT issued a read last cycle (no flush since)

  logic s_rd, s_valid;
  pc_t  s_addr, s_pc;
  logic [CW-1:0] s_count;
  pc_t  xfer_q [$];

  task automatic model_reset();
    words_buffered  = 0;
    words_returning = 0;
    next_read       = '0;
    next_deliver    = '0;
    dut_read_prev   = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample, compare, advance the model.
  task automatic step(input logic rdy, input logic hlt, input logic clr,
                      input logic rdr, input pc_t rpc);
    int   take, room_used;
    logic exp_rd;
    @(negedge clk);
    ir_ready = rdy; halt = hlt; pc_clr = clr; redirect = rdr; redirect_pc = rpc;
    #1;
    s_rd = imem_rd_en; s_addr = imem_addr; s_valid = ir_valid;
    s_pc = ir_pc; s_count = fifo_count;
    take = (words_buffered != 0 && rdy) ? 1 : 0;
    check_val("fifo_count", 32'(fifo_count), 32'(words_buffered));
    check_val("ir_valid", 32'(ir_valid), 32'(words_buffered != 0));
    if (words_buffered != 0) begin
      check_val("ir_pc", 32'(ir_pc), 32'(next_deliver));
      check_val("ir_data", 32'(ir_data), 32'(rom[next_deliver]));
    end
    check_val("imem_addr", 32'(imem_addr), 32'(next_read));
    room_used = words_buffered + words_returning - take;
    exp_rd = !hlt && !clr && !rdr && (room_used < DEPTH);
    check_val("imem_rd_en", 32'(imem_rd_en), 32'(exp_rd));
    if (dut_read_prev && !(clr || rdr))
      check_val("push_room", 32'((int'(fifo_count) - int'(ir_valid && rdy)) < DEPTH), 32'd1);
    if (ir_valid && rdy) xfer_q.push_back(ir_pc);
    if (take != 0) next_deliver = next_deliver + pc_t'(1);
    if (clr || rdr) begin
      next_read       = clr ? pc_t'(0) : rpc;
      next_deliver    = next_read;
      words_buffered  = 0;
      words_returning = 0;
      dut_read_prev   = 1'b0;
    end else begin
      words_buffered  = room_used;
      words_returning = exp_rd ? 1 : 0;
      if (exp_rd) next_read = next_read + pc_t'(1);
      dut_read_prev   = s_rd;
    end
  endtask

  // Asynchronous reset away from any edge; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check_val("rst_valid", 32'(ir_valid), 32'd0);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'd0);
    check_val("rst_ir_pc", 32'(ir_pc), 32'd0);
    check_val("rst_ir_data", 32'(ir_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n50, budget;
    for (int i = 0; i < 128; i++) rom[i] = instr_t'(16'hA000 + i);
    model_reset();
    ir_ready = 1'b1;

    // Reset state, then free-running stream with the controller always ready.
    async_reset();
    repeat (12) step(1, 0, 0, 0, '0);

    // Back-pressure right after reset: buffer fills to DEPTH, reads stop at 2.
    async_reset();
    repeat (6) step(0, 0, 0, 0, '0);
    check_val("sat_count", 32'(s_count), 32'(DEPTH));
    check_val("sat_rd_en", 32'(s_rd), 32'd0);
    check_val("sat_fpc", 32'(s_addr), 32'd2);
    repeat (8) step(1, 0, 0, 0, '0);

    // Redirect to 100 while pc 5 is at the head and being taken.
    async_reset();
    budget = 0;
    while (!(words_buffered != 0 && next_deliver == pc_t'(5)) && budget < 40) begin
      step(1, 0, 0, 0, '0);
      budget++;
    end
    check_val("wait_head5", 32'(budget < 40), 32'd1);
    step(1, 0, 0, 1, pc_t'(100));
    check_val("redir_pop_pc", 32'(s_pc), 32'd5);
    step(1, 0, 0, 0, '0);
    check_val("redir_rd_en", 32'(s_rd), 32'd1);
    check_val("redir_addr", 32'(s_addr), 32'd100);
    repeat (6) step(1, 0, 0, 0, '0);

    // Clear and redirect together: clear wins, 50 is never read.
    step(1, 0, 1, 1, pc_t'(50));
    n50 = 0;
    repeat (10) begin
      step(1, 0, 0, 0, '0);
      if (s_rd && s_addr == pc_t'(50)) n50++;
    end
    check_val("clr_prio_no50", 32'(n50), 32'd0);

    // Wrap from 127 to 0.
    step(1, 0, 0, 1, pc_t'(126));
    xfer_q.delete();
    repeat (8) step(1, 0, 0, 0, '0);
    check_val("wrap_len", 32'(xfer_q.size() >= 4), 32'd1);
    if (xfer_q.size() >= 4) begin
      check_val("wrap_0", 32'(xfer_q[0]), 32'd126);
      check_val("wrap_1", 32'(xfer_q[1]), 32'd127);
      check_val("wrap_2", 32'(xfer_q[2]), 32'd0);
      check_val("wrap_3", 32'(xfer_q[3]), 32'd1);
    end

    // Halt for 4 cycles with a read in flight; the word is still captured.
    check_val("halt_inflight", 32'(words_returning), 32'd1);
    repeat (4) begin
      step(0, 1, 0, 0, '0);
      check_val("halt_no_rd", 32'(s_rd), 32'd0);
    end
    repeat (6) step(1, 0, 0, 0, '0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic r, h, pcl, rd;
      r   = ($urandom_range(0, 9) < 7);
      h   = ($urandom_range(0, 9) == 0);
      pcl = ($urandom_range(0, 49) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      step(r, h, pcl, rd, pc_t'($urandom_range(0, 127)));
    end

    // Reset mid-stream.
    async_reset();
    repeat (4) step(1, 0, 0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
